// File: rtl/sram_readback_streamer.sv
// Sweeps a contiguous SRAM range through the controller read port and streams the
// returned words, tagged with their addresses, through a credit-limited output FIFO.
module sram_readback_streamer #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              tx_mode,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
);
  localparam int LEN_W = ADDR_W + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic              busy_q, done_q;
  logic [ADDR_W-1:0] rd_addr_q, base_q;
  logic [LEN_W-1:0]  len_q, issued_q, popped_q;

  logic [RD_LAT-1:0] pv_q;
  logic [ADDR_W-1:0] pa_q [RD_LAT];
  logic              cap_v_q;
  logic [ADDR_W-1:0] cap_a_q;
  logic [DATA_W-1:0] cap_d_q;

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d, infl_q, infl_d;

  logic              abort_s, credit_s, issue_s, push_s, pop_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic [LEN_W-1:0]  issued_inc_s, popped_inc_s;

  // Words in flight (pipeline + capture) count against FIFO space, so a push never overflows.
  assign abort_s      = abort && (state_q != S_IDLE);
  assign credit_s     = (fifo_cnt_q + infl_q) < CNT_W'(FIFO_DEPTH);
  assign issue_s      = (state_q == S_ISSUE) && credit_s && !abort;
  assign push_s       = cap_v_q;
  assign pop_s        = (fifo_cnt_q != CNT_W'(0)) && out_ready;
  assign next_addr_s  = base_q + issued_q[ADDR_W-1:0];
  assign issued_inc_s = issued_q + LEN_W'(1);
  assign popped_inc_s = popped_q + LEN_W'(1);

  assign busy      = busy_q;
  assign tx_mode   = busy_q;
  assign done      = done_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = (fifo_cnt_q != CNT_W'(0));
  assign {out_addr, out_data} = mem_q[rd_ptr_q];

  always_comb begin
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
    infl_d     = infl_q + CNT_W'(issue_s) - CNT_W'(push_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
      base_q    <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      popped_q  <= '0;
    end else if (abort_s) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop_s) popped_q <= popped_inc_s;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            len_q    <= length;
            issued_q <= '0;
            popped_q <= '0;
            busy_q   <= 1'b1;
            if (length == LEN_W'(0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (issue_s) begin
            rd_addr_q <= next_addr_s;
            issued_q  <= issued_inc_s;
            if (issued_inc_s == len_q) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop_s && (popped_inc_s == len_q)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Address tags ride alongside the read latency; rd_data is captured when the tag emerges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) pa_q[i] <= '0;
      cap_v_q <= 1'b0;
      cap_a_q <= '0;
      cap_d_q <= '0;
    end else if (abort_s) begin
      pv_q    <= '0;
      cap_v_q <= 1'b0;
    end else begin
      pv_q[0] <= issue_s;
      pa_q[0] <= next_addr_s;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
      cap_v_q <= pv_q[RD_LAT-1];
      cap_a_q <= pa_q[RD_LAT-1];
      cap_d_q <= rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      infl_q     <= '0;
    end else if (abort_s) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      infl_q     <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {cap_a_q, cap_d_q};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_d;
      infl_q     <= infl_d;
    end
  end
endmodule
